// File: rtl/sdp_ram_access_arbiter_pkg.sv
// Shared types and helpers for the SDP RAM access arbiter.
// FSM state encoding and address-width helper.
package sdp_ram_access_arbiter_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Number of bits needed to represent val (log2b(511) = 9).
   function automatic int log2b(input int val);
      int res;
      res = 0;
      for (int i = 0; i < 31; i++) begin
         if ((val >> i) != 0) res = i + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/sdp_ram_access_arbiter_rr.sv
// Two-way round-robin arbiter with combinational grant.
// Pointer names the client that wins the next contended cycle.
module sdp_ram_access_arbiter_rr (
   input  logic       clk,
   input  logic       rst,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic ptr_q, ptr_d;

   // Grant a lone requester, or the pointed-at client on contention.
   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
         endcase
      end
      ptr_d = ptr_q;
      if (gnt_o[0]) ptr_d = 1'b1;
      else if (gnt_o[1]) ptr_d = 1'b0;
   end

   // Pointer moves to the other client after every grant.
   always_ff @(posedge clk) begin
      if (rst) ptr_q <= 1'b0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/sdp_ram_access_arbiter.sv
// Shares one simple-dual-port RAM among two writers and two readers.
// Zero-fills the RAM after reset, then arbitrates each port round-robin.
module sdp_ram_access_arbiter
   import sdp_ram_access_arbiter_pkg::*;
#(
   parameter int RAM_WIDTH  = 52,
   parameter int RAM_DEPTH  = 512,
   parameter int ADDR_WIDTH = log2b(RAM_DEPTH - 1),
   parameter int INIT_EN    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr0_req_valid,
   input  logic [ADDR_WIDTH-1:0] wr0_req_addr,
   input  logic [RAM_WIDTH-1:0]  wr0_req_data,
   output logic                  wr0_req_ready,
   input  logic                  wr1_req_valid,
   input  logic [ADDR_WIDTH-1:0] wr1_req_addr,
   input  logic [RAM_WIDTH-1:0]  wr1_req_data,
   output logic                  wr1_req_ready,
   input  logic                  rd0_req_valid,
   input  logic [ADDR_WIDTH-1:0] rd0_req_addr,
   output logic                  rd0_req_ready,
   output logic                  rd0_rsp_valid,
   output logic [RAM_WIDTH-1:0]  rd0_rsp_data,
   input  logic                  rd1_req_valid,
   input  logic [ADDR_WIDTH-1:0] rd1_req_addr,
   output logic                  rd1_req_ready,
   output logic                  rd1_rsp_valid,
   output logic [RAM_WIDTH-1:0]  rd1_rsp_data,
   output logic                  ram_wea,
   output logic [ADDR_WIDTH-1:0] ram_addra,
   output logic [RAM_WIDTH-1:0]  ram_dina,
   output logic [ADDR_WIDTH-1:0] ram_addrb,
   input  logic [RAM_WIDTH-1:0]  ram_doutb,
   output logic                  init_done
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] cnt_q;
   logic                  init_done_q;
   logic                  rsp_vld_q;
   logic                  rsp_id_q;
   logic [ADDR_WIDTH-1:0] addrb_q;

   logic       run;
   logic       filling;
   logic [1:0] wr_gnt;
   logic [1:0] rd_gnt;

   assign run     = (state_q == ST_RUN) && !rst;
   assign filling = (state_q == ST_INIT) && !rst;

   sdp_ram_access_arbiter_rr u_wr_arb (
      .clk   (clk),
      .rst   (rst),
      .en_i  (run),
      .req_i ({wr1_req_valid, wr0_req_valid}),
      .gnt_o (wr_gnt)
   );

   sdp_ram_access_arbiter_rr u_rd_arb (
      .clk   (clk),
      .rst   (rst),
      .en_i  (run),
      .req_i ({rd1_req_valid, rd0_req_valid}),
      .gnt_o (rd_gnt)
   );

   assign wr0_req_ready = wr_gnt[0];
   assign wr1_req_ready = wr_gnt[1];
   assign rd0_req_ready = rd_gnt[0];
   assign rd1_req_ready = rd_gnt[1];

   // Write port: fill counter during INIT, granted client during RUN.
   always_comb begin
      ram_wea   = filling | (|wr_gnt);
      ram_addra = cnt_q;
      ram_dina  = '0;
      if (wr_gnt[1]) begin
         ram_addra = wr1_req_addr;
         ram_dina  = wr1_req_data;
      end else if (wr_gnt[0]) begin
         ram_addra = wr0_req_addr;
         ram_dina  = wr0_req_data;
      end
   end

   // Read port: granted address, otherwise hold the previous one.
   always_comb begin
      ram_addrb = addrb_q;
      if (rd_gnt[1])      ram_addrb = rd1_req_addr;
      else if (rd_gnt[0]) ram_addrb = rd0_req_addr;
   end

   // Responses are dropped combinationally while rst is held.
   assign rd0_rsp_valid = rsp_vld_q & ~rsp_id_q & ~rst;
   assign rd1_rsp_valid = rsp_vld_q &  rsp_id_q & ~rst;
   assign rd0_rsp_data  = ram_doutb;
   assign rd1_rsp_data  = ram_doutb;
   assign init_done     = init_done_q & ~rst;

   // INIT/RUN sequencing, fill counter and read-response tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
         cnt_q       <= '0;
         init_done_q <= (INIT_EN == 0);
         rsp_vld_q   <= 1'b0;
         rsp_id_q    <= 1'b0;
         addrb_q     <= '0;
      end else begin
         rsp_vld_q <= |rd_gnt;
         rsp_id_q  <= rd_gnt[1];
         addrb_q   <= ram_addrb;
         unique case (state_q)
            ST_INIT: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_ADDR) begin
                  state_q     <= ST_RUN;
                  init_done_q <= 1'b1;
               end
            end
            ST_RUN: begin
               state_q <= ST_RUN;
            end
            default: begin
               state_q <= ST_INIT;
            end
         endcase
      end
   end

endmodule
